two_addr_useq: RTL and testbench
================================

# two_addr_useq

Two-address microcode sequencer that drives the control unit's next-state path. It holds a writable 8-word microcode store and steps a 3-bit micro-PC through it. Each cycle it presents the current word's control field, evaluates the selected condition, and loads one of two next addresses. Optional ack-wait stalls let the sequencer hold on a word until the datapath acknowledges.

## Interface
- STATE_W, 3, micro-PC width; store depth is 2**STATE_W.
- CTRL_W, 8, control-field width.
- TIMEOUT, 15, max stall cycles on a wait word; used only with the timeout feature.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high. Clock is clk.
- start  in  1  begin execution at address 0; honoured only when idle.
- cond  in  4  datapath condition flags.
- ack  in  1  datapath acknowledge for wait words.
- ucode_we  in  1  microcode write strobe.
- ucode_addr  in  STATE_W  write address.
- ucode_wdata  in  CTRL_W+10  microword.
- ctrl_out  out  CTRL_W  control field of the current word; 0 when idle.
- state_out  out  STATE_W  micro-PC.
- busy  out  1  sequencer in RUN.
- done  out  1  one-cycle pulse after a halt word completes.
- fault  out  1  sticky wait-timeout flag.

## Operation
- Microword layout, MSB to LSB:
  - ctrl[CTRL_W+9:10]
  - csel[9:7]
  - wait[6]
  - addr_t[5:3]
  - addr_f[2:0]
- csel encoding:
  - 0: always true
  - 1 to 4: cond[0] to cond[3]
  - 5: !cond[0]
  - 6: !cond[1]
  - 7: halt
- FSM has two states, IDLE and RUN.
- IDLE behaviour:
  - start causes upc<=0 and a move to RUN.
  - ucode_we writes mem[ucode_addr]<=ucode_wdata.
- RUN behaviour:
  - ctrl_out = mem[upc].ctrl, read combinationally from the registered upc.
  - If wait=1 and ack=0, hold upc.
  - Otherwise, if csel=7, go to IDLE and pulse done.
  - Otherwise, upc <= condition ? addr_t : addr_f.
- ucode_we is ignored while busy. start is ignored while busy.
- start and ucode_we in the same IDLE cycle: both take effect, and the new word is visible when RUN begins.
- start clears fault.
- Reset:
  - clears all memory words to 0, so a zero word means "loop at address 0".
  - state goes to IDLE; upc, done and fault go to 0.
  - reset mid-run aborts immediately.
- Micro-PC wraps naturally; any 3-bit address is valid.

## Timing
- Reset values: ctrl_out=0, state_out=0, busy=0, done=0, fault=0.
- start sampled at edge N: busy=1, state_out=0 and ctrl_out=mem[0].ctrl from cycle N+1.
- Each non-stalled word occupies exactly one cycle.
- A wait word with ack already high costs no extra cycle.
- A halt word presented in cycle M gives busy=0 and done=1 in cycle M+1. done=0 in cycle M+2.
- Back-to-back: start during the done cycle is accepted, since the FSM is in IDLE.

## Configuration
- USEQ_TIMEOUT_EN defined:
  - A stall counter clears on each upc advance and increments on every stalled cycle.
  - When it reaches TIMEOUT with ack still low, fault<=1, FSM goes to IDLE, done stays 0.
- USEQ_TIMEOUT_EN undefined:
  - Stalls are unbounded.
  - fault is tied to 0 and no counter is built.

## Structure
- Shared package useq_pkg holds:
  - field bit positions
  - csel encodings, including CSEL_HALT=7
  - the FSM state typedef
  - microword width constant
- One natural sub-module, useq_store: the 8×(CTRL_W+10) register-file store, with synchronous write, asynchronous read and synchronous clear.

## Test plan
- Linear and halt:
  - Stimulus: write word0 = ctrl 0x11, csel 0, addr_t 1; write word1 = ctrl 0x22, csel 7; pulse start.
  - Response: ctrl_out 0x11 then 0x22; done=1 one cycle later; busy=0.
- Branch:
  - Stimulus: word0 csel 1, addr_t 3, addr_f 2.
  - Response: with cond=4'b0001, state_out goes 0→3; with cond=0, it goes 0→2.
- Wait:
  - Stimulus: word0 wait=1, addr_t 1; word1 halt; ack low for 5 cycles, then high.
  - Response: state_out=0 for 6 cycles, then 1, then done pulse.
- Timeout (USEQ_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: wait word with ack never asserted.
  - Response: after 4 stalled cycles, fault=1, busy=0, done=0; next start clears fault.
- Reset mid-run:
  - Stimulus: assert reset while upc=3.
  - Response: next cycle busy=0, state_out=0, ctrl_out=0; a subsequent start loops at address 0 with ctrl_out=0.
- Write while busy:
  - Stimulus: ucode_we to word1 during RUN.
  - Response: the write is ignored and the original word1 executes.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared definitions for the two-address microcode sequencer: microword field
// positions, condition-select encodings, FSM state type and word width.
package useq_pkg;

  localparam int USEQ_STATE_W = 3;
  localparam int USEQ_CTRL_W  = 8;
  localparam int USEQ_LOW_W   = 10;
  localparam int USEQ_WORD_W  = USEQ_CTRL_W + USEQ_LOW_W;

  // Microword layout, MSB to LSB: ctrl | csel | wait | addr_t | addr_f
  localparam int F_CTRL_LSB   = 10;
  localparam int F_CSEL_MSB   = 9;
  localparam int F_CSEL_LSB   = 7;
  localparam int F_WAIT       = 6;
  localparam int F_ADDR_T_MSB = 5;
  localparam int F_ADDR_T_LSB = 3;
  localparam int F_ADDR_F_MSB = 2;
  localparam int F_ADDR_F_LSB = 0;

  localparam logic [2:0] CSEL_ALWAYS = 3'd0;
  localparam logic [2:0] CSEL_C0     = 3'd1;
  localparam logic [2:0] CSEL_C1     = 3'd2;
  localparam logic [2:0] CSEL_C2     = 3'd3;
  localparam logic [2:0] CSEL_C3     = 3'd4;
  localparam logic [2:0] CSEL_NC0    = 3'd5;
  localparam logic [2:0] CSEL_NC1    = 3'd6;
  localparam logic [2:0] CSEL_HALT   = 3'd7;

  typedef logic [0:0] useq_state_t;
  localparam useq_state_t ST_IDLE = 1'b0;
  localparam useq_state_t ST_RUN  = 1'b1;

  // Branch condition for a word; a halt word never branches.
  function automatic logic cond_eval(input logic [2:0] csel, input logic [3:0] cond);
    logic r;
    r = 1'b0;
    case (csel)
      CSEL_ALWAYS: r = 1'b1;
      CSEL_C0:     r = cond[0];
      CSEL_C1:     r = cond[1];
      CSEL_C2:     r = cond[2];
      CSEL_C3:     r = cond[3];
      CSEL_NC0:    r = ~cond[0];
      CSEL_NC1:    r = ~cond[1];
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/useq_store.sv
// Microcode register file: synchronous write, asynchronous read, and a
// synchronous clear so a fresh store reads as "loop at address 0".
module useq_store #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: this store is a small flop array, not a RAM macro, so clearing it on
  // reset is legal and intentional; zero words define post-reset behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/two_addr_useq.sv
// Two-address microcode sequencer: steps a micro-PC through an 8-word store.
// Define USEQ_TIMEOUT_EN to bound ack-wait stalls and raise a sticky fault.
module two_addr_useq
  import useq_pkg::*;
#(
  parameter int STATE_W = USEQ_STATE_W,
  parameter int CTRL_W  = USEQ_CTRL_W,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           cond,
  input  logic                 ack,
  input  logic                 ucode_we,
  input  logic [STATE_W-1:0]   ucode_addr,
  input  logic [CTRL_W+9:0]    ucode_wdata,
  output logic [CTRL_W-1:0]    ctrl_out,
  output logic [STATE_W-1:0]   state_out,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  localparam int WORD_W = CTRL_W + USEQ_LOW_W;

  useq_state_t         state;
  logic [STATE_W-1:0]  upc;
  logic                done_r;
  logic [WORD_W-1:0]   word;
  logic [2:0]          csel;
  logic                wait_bit;
  logic                stall;
  logic                timeout_hit;
  logic [STATE_W-1:0]  next_upc;

  useq_store #(.ADDR_W(STATE_W), .WORD_W(WORD_W)) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (ucode_we && (state == ST_IDLE)),
    .waddr (ucode_addr),
    .wdata (ucode_wdata),
    .raddr (upc),
    .rdata (word)
  );

  assign csel     = word[F_CSEL_MSB:F_CSEL_LSB];
  assign wait_bit = word[F_WAIT];
  assign stall    = wait_bit && !ack;
  assign next_upc = cond_eval(csel, cond) ? STATE_W'(word[F_ADDR_T_MSB:F_ADDR_T_LSB])
                                          : STATE_W'(word[F_ADDR_F_MSB:F_ADDR_F_LSB]);

`ifdef USEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             fault_r;

  assign timeout_hit = (state == ST_RUN) && stall && (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fault_r   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        stall_cnt <= '0;
        fault_r   <= 1'b0;
      end
    end else if (timeout_hit) begin
      stall_cnt <= '0;
      fault_r   <= 1'b1;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  assign fault = fault_r;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      upc    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            upc   <= '0;
            state <= ST_RUN;
          end
        end
        default: begin
          if (timeout_hit) begin
            state <= ST_IDLE;
          end else if (stall) begin
            upc <= upc;
          end else if (csel == CSEL_HALT) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
          end else begin
            upc <= next_upc;
          end
        end
      endcase
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = done_r;
  assign state_out = upc;
  assign ctrl_out  = busy ? word[F_CTRL_LSB +: CTRL_W] : '0;

endmodule

// File: tb/tb_two_addr_useq.sv
// Self-checking bench for two_addr_useq: directed scenarios plus randomized
// traffic checked against a behavioural model of the sequencer.
module tb_two_addr_useq;

  localparam int TIMEOUT = 4;
`ifdef USEQ_TIMEOUT_EN
  localparam int WAIT_LOW = 3;
`else
  localparam int WAIT_LOW = 5;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cond = 4'd0;
  logic        ack = 1'b0;
  logic        ucode_we = 1'b0;
  logic [2:0]  ucode_addr = 3'd0;
  logic [17:0] ucode_wdata = 18'd0;
  logic [7:0]  ctrl_out;
  logic [2:0]  state_out;
  logic        busy, done, fault;

  int n_cmp = 0;
  int n_bad = 0;

  two_addr_useq #(.STATE_W(3), .CTRL_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .cond(cond), .ack(ack),
    .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata),
    .ctrl_out(ctrl_out), .state_out(state_out), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Behavioural model: store contents plus architectural state.
  logic [17:0] m_mem [8];
  int          m_upc = 0;
  bit          m_busy = 0, m_done = 0, m_fault = 0;
  int          m_cnt = 0;

  function automatic logic [17:0] mk(input int ctrl, input int csel, input int w,
                                     input int at, input int af);
    logic [17:0] r;
    r[17:10] = 8'(ctrl);
    r[9:7]   = 3'(csel);
    r[6]     = w[0];
    r[5:3]   = 3'(at);
    r[2:0]   = 3'(af);
    return r;
  endfunction

  function automatic bit cond_true(input int csel, input logic [3:0] c);
    if (csel == 0) return 1;
    if (csel >= 1 && csel <= 4) return c[csel-1];
    if (csel == 5) return !c[0];
    if (csel == 6) return !c[1];
    return 0;
  endfunction

  task automatic model_update();
    logic [17:0] w;
    int csel;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_busy = 0; m_upc = 0; m_done = 0; m_fault = 0; m_cnt = 0;
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (ucode_we) m_mem[ucode_addr] = ucode_wdata;
      if (start) begin
        m_busy = 1; m_upc = 0; m_fault = 0; m_cnt = 0;
      end
      return;
    end
    w = m_mem[m_upc];
    csel = int'(w[9:7]);
    if (w[6] && !ack) begin
`ifdef USEQ_TIMEOUT_EN
      m_cnt++;
      if (m_cnt == TIMEOUT) begin
        m_fault = 1; m_busy = 0; m_cnt = 0;
      end
`endif
    end else if (csel == 7) begin
      m_busy = 0; m_done = 1;
    end else begin
      m_upc = cond_true(csel, cond) ? int'(w[5:3]) : int'(w[2:0]);
      m_cnt = 0;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [17:0] data);
    ucode_we = 1'b1; ucode_addr = 3'(addr); ucode_wdata = data;
    tick();
    ucode_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (ctrl_out !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got %h want 00", ctrl_out); end
    n_cmp++; if (state_out !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fault); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_linear_halt();
    write_word(0, mk(8'h11, 0, 0, 1, 0));
    write_word(1, mk(8'h22, 7, 0, 0, 0));
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (ctrl_out !== 8'h11 || busy !== 1'b1 || state_out !== 3'd0) begin
      n_bad++; $display("FAIL lin_first got ctrl=%h busy=%b st=%0d want 11/1/0", ctrl_out, busy, state_out); end
    tick();
    n_cmp++; if (ctrl_out !== 8'h22 || state_out !== 3'd1) begin
      n_bad++; $display("FAIL lin_second got ctrl=%h st=%0d want 22/1", ctrl_out, state_out); end
    tick();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || ctrl_out !== 8'h00) begin
      n_bad++; $display("FAIL lin_done got done=%b busy=%b ctrl=%h want 1/0/00", done, busy, ctrl_out); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lin_done_pulse got %b want 0", done); end
  endtask

  task automatic test_branch();
    write_word(0, mk(8'hA0, 1, 0, 3, 2));
    write_word(2, mk(8'h2B, 7, 0, 0, 0));
    write_word(3, mk(8'h3B, 7, 0, 0, 0));
    cond = 4'b0001;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_cmp++; if (state_out !== 3'd3 || ctrl_out !== 8'h3B) begin
      n_bad++; $display("FAIL br_taken got st=%0d ctrl=%h want 3/3b", state_out, ctrl_out); end
    tick(); tick();
    cond = 4'b0000;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_cmp++; if (state_out !== 3'd2 || ctrl_out !== 8'h2B) begin
      n_bad++; $display("FAIL br_not_taken got st=%0d ctrl=%h want 2/2b", state_out, ctrl_out); end
    tick(); tick();
  endtask

  task automatic test_wait();
    write_word(0, mk(8'h0A, 0, 1, 1, 1));
    write_word(1, mk(8'h1A, 7, 0, 0, 0));
    ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < WAIT_LOW; i++) begin
      n_cmp++; if (state_out !== 3'd0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL wait_hold[%0d] got st=%0d busy=%b want 0/1", i, state_out, busy); end
      tick();
    end
    ack = 1'b1;
    n_cmp++; if (state_out !== 3'd0) begin n_bad++; $display("FAIL wait_last got st=%0d want 0", state_out); end
    tick();
    ack = 1'b0;
    n_cmp++; if (state_out !== 3'd1 || ctrl_out !== 8'h1A) begin
      n_bad++; $display("FAIL wait_advance got st=%0d ctrl=%h want 1/1a", state_out, ctrl_out); end
    tick();
    n_cmp++; if (done !== 1'b1 || fault !== 1'b0) begin
      n_bad++; $display("FAIL wait_done got done=%b fault=%b want 1/0", done, fault); end
    tick();
  endtask

  task automatic test_write_busy();
    write_word(0, mk(8'h33, 0, 0, 1, 1));
    write_word(1, mk(8'h44, 7, 0, 0, 0));
    start = 1'b1; tick(); start = 1'b0;
    ucode_we = 1'b1; ucode_addr = 3'd1; ucode_wdata = mk(8'h55, 0, 0, 0, 0);
    tick();
    ucode_we = 1'b0;
    n_cmp++; if (ctrl_out !== 8'h44) begin n_bad++; $display("FAIL wbusy_exec got %h want 44", ctrl_out); end
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_cmp++; if (ctrl_out !== 8'h44) begin n_bad++; $display("FAIL wbusy_kept got %h want 44", ctrl_out); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    write_word(0, mk(8'h5A, 7, 0, 0, 0));
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || state_out !== 3'd0 || ctrl_out !== 8'h5A) begin
      n_bad++; $display("FAIL b2b_restart got busy=%b st=%0d ctrl=%h want 1/0/5a", busy, state_out, ctrl_out); end
    tick(); tick();
  endtask

  task automatic test_same_cycle();
    start = 1'b1; ucode_we = 1'b1; ucode_addr = 3'd0; ucode_wdata = mk(8'hC3, 7, 0, 0, 0);
    tick();
    start = 1'b0; ucode_we = 1'b0;
    n_cmp++; if (ctrl_out !== 8'hC3 || busy !== 1'b1) begin
      n_bad++; $display("FAIL same_cycle got ctrl=%h busy=%b want c3/1", ctrl_out, busy); end
    tick(); tick();
  endtask

  task automatic test_reset_midrun();
    write_word(0, mk(8'h10, 0, 0, 3, 3));
    write_word(3, mk(8'h77, 0, 0, 3, 3));
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_cmp++; if (state_out !== 3'd3) begin n_bad++; $display("FAIL mid_at3 got %0d want 3", state_out); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (busy !== 1'b0 || state_out !== 3'd0 || ctrl_out !== 8'h00) begin
      n_bad++; $display("FAIL mid_abort got busy=%b st=%0d ctrl=%h want 0/0/00", busy, state_out, ctrl_out); end
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1 || state_out !== 3'd0 || ctrl_out !== 8'h00) begin
      n_bad++; $display("FAIL mid_zero_loop got busy=%b st=%0d ctrl=%h want 1/0/00", busy, state_out, ctrl_out); end
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

`ifdef USEQ_TIMEOUT_EN
  task automatic test_timeout();
    write_word(0, mk(8'h99, 0, 1, 1, 1));
    ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b1 || fault !== 1'b0) begin
      n_bad++; $display("FAIL to_before got busy=%b fault=%b want 1/0", busy, fault); end
    tick();
    n_cmp++; if (fault !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL to_hit got fault=%b busy=%b done=%b want 1/0/0", fault, busy, done); end
    start = 1'b1; ack = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (fault !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL to_clear got fault=%b busy=%b want 0/1", fault, busy); end
    ack = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] e_ctrl;
    for (int i = 0; i < 8; i++)
      write_word(i, mk($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 7)));
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 79) == 0);
      start       = ($urandom_range(0, 3) == 0);
      ack         = ($urandom_range(0, 3) != 0);
      cond        = 4'($urandom_range(0, 15));
      ucode_we    = ($urandom_range(0, 2) == 0);
      ucode_addr  = 3'($urandom_range(0, 7));
      ucode_wdata = mk($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 7));
      tick();
      e_ctrl = m_busy ? m_mem[m_upc][17:10] : 8'h00;
      n_cmp++;
      if (ctrl_out !== e_ctrl || state_out !== 3'(m_upc) || busy !== m_busy ||
          done !== m_done || fault !== m_fault) begin
        n_bad++;
        $display("FAIL rand[%0d] got ctrl=%h st=%0d b=%b d=%b f=%b want ctrl=%h st=%0d b=%b d=%b f=%b",
                 n, ctrl_out, state_out, busy, done, fault, e_ctrl, m_upc, m_busy, m_done, m_fault);
      end
    end
    reset = 1'b0; start = 1'b0; ucode_we = 1'b0; ack = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    #2;
    test_reset();
    test_linear_halt();
    test_branch();
    test_wait();
    test_write_busy();
    test_back_to_back();
    test_same_cycle();
    test_reset_midrun();
`ifdef USEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
